// File: rtl/noc_input_stage.sv
// ---------------------------------------------------------------------------
// noc_input_stage
//
// Router input stage: buffers flits from one input link in one FIFO per
// virtual channel, computes XY routes from head flits, keeps a wormhole route
// lock per VC until the tail flit leaves, and presents one flit per cycle on
// one of the four output-side request lanes (own direction excluded).
//
// Ports:
//   clk          clock
//   arst         asynchronous reset, active-high
//   fin_req_i    flit from link (valid, vc_id, fdata)
//   fin_resp_o   ready back to link (combinational on the addressed VC's full)
//   fout_req_o   one request lane per output stage; at most one lane valid
//   fout_resp_i  ready from each output stage
//   err_o        one-cycle pulse for each dropped flit
//   err_cnt_o    saturating count of dropped flits (only with the macro below)
//
// Build option:
//   RAVENOC_IN_ERR_CNT_EN  adds err_cnt_o[15:0] and its saturating counter.
//
// Flit layout (MSB first): type[1:0] | x_dest | y_dest | pkt_size | payload.
// ---------------------------------------------------------------------------
package noc_input_stage_pkg;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
  localparam int XW     = 2;
  localparam int YW     = 2;
  localparam int SZW    = 3;
  localparam int PLW    = 25;
  localparam int FLIT_W = 2 + XW + YW + SZW + PLW;

  localparam int TYPE_LSB = FLIT_W - 2;
  localparam int X_LSB    = TYPE_LSB - XW;
  localparam int Y_LSB    = X_LSB - YW;
  localparam int SZ_LSB   = Y_LSB - SZW;

  // Highest VC index wins arbitration when set, lowest otherwise.
  localparam logic H_PRIORITY = 1'b1;

  localparam logic [SZW-1:0] MIN_SIZE_FLIT = '0;

  localparam logic [2:0] NORTH_DIR = 3'd0;
  localparam logic [2:0] SOUTH_DIR = 3'd1;
  localparam logic [2:0] WEST_DIR  = 3'd2;
  localparam logic [2:0] EAST_DIR  = 3'd3;
  localparam logic [2:0] LOCAL_DIR = 3'd4;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_e;

  typedef struct packed {
    flit_type_e       ftype;
    logic [XW-1:0]    x_dest;
    logic [YW-1:0]    y_dest;
    logic [SZW-1:0]   pkt_size;
    logic [PLW-1:0]   payload;
  } s_head_flit_t;

  typedef struct packed {
    logic              valid;
    logic [VC_W-1:0]   vc_id;
    logic [FLIT_W-1:0] fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;
endpackage

// VC FSM states:
//   ST_HEAD | FIFO head must be a head flit; route is computed from it
//   ST_BODY | packet in flight; flits follow the locked route_q of the VC
module noc_input_stage
  import noc_input_stage_pkg::*;
#(
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  parameter int IN_PORT     = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  s_flit_req_t        fin_req_i,
  output s_flit_resp_t       fin_resp_o,
  output s_flit_req_t [3:0]  fout_req_o,
  input  s_flit_resp_t [3:0] fout_resp_i,
  output logic               err_o
`ifdef RAVENOC_IN_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [XW-1:0] MY_X   = XW'(ROUTER_X_ID);
  localparam logic [YW-1:0] MY_Y   = YW'(ROUTER_Y_ID);
  localparam logic [2:0]    IN_DIR = 3'(IN_PORT);

  typedef enum logic {ST_HEAD, ST_BODY} state_e;

  logic [FLIT_W-1:0] mem_q [NUM_VC][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_VC];
  logic [PW-1:0]     wr_ptr_d [NUM_VC];
  logic [PW-1:0]     rd_ptr_q [NUM_VC];
  logic [PW-1:0]     rd_ptr_d [NUM_VC];
  state_e            state_q  [NUM_VC];
  state_e            state_d  [NUM_VC];
  logic [1:0]        route_q  [NUM_VC];
  logic [1:0]        route_d  [NUM_VC];
  logic              err_q, err_d;

  logic [NUM_VC-1:0] full, empty;
  logic              wr_en;
  logic              sel_valid;
  logic [VC_W-1:0]   sel_vc;
  logic [FLIT_W-1:0] head_data;
  flit_type_e        hd_type;
  logic [2:0]        hd_dir;
  logic [1:0]        hd_lane;
  logic              present, drop, accept, pop;
  logic [1:0]        out_lane;

  function automatic logic [2:0] xy_dir(input logic [XW-1:0] xd,
                                        input logic [YW-1:0] yd);
    if (xd > MY_X)      return EAST_DIR;
    else if (xd < MY_X) return WEST_DIR;
    else if (yd > MY_Y) return SOUTH_DIR;
    else if (yd < MY_Y) return NORTH_DIR;
    else                return LOCAL_DIR;
  endfunction

  // Own direction has no lane, so directions above it shift down by one.
  function automatic logic [1:0] lane_of(input logic [2:0] dir);
    if (dir < IN_DIR) return dir[1:0];
    else              return 2'(dir - 3'd1);
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]  = (wr_ptr_q[v][PW-1] != rd_ptr_q[v][PW-1]) &&
                 (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
      empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
    end
  end

  // Ready is held low while in reset so nothing is accepted then.
  always_comb begin
    fin_resp_o       = '0;
    fin_resp_o.ready = !arst && !full[fin_req_i.vc_id];
  end

  assign wr_en = fin_req_i.valid && fin_resp_o.ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (!empty[v] && (H_PRIORITY || !sel_valid)) begin
        sel_valid = 1'b1;
        sel_vc    = VC_W'(v);
      end
    end
  end

  assign head_data = mem_q[sel_vc][rd_ptr_q[sel_vc][AW-1:0]];
  assign hd_type   = flit_type_e'(head_data[TYPE_LSB +: 2]);
  assign hd_dir    = xy_dir(head_data[X_LSB +: XW], head_data[Y_LSB +: YW]);
  assign hd_lane   = lane_of(hd_dir);

  always_comb begin
    present  = 1'b0;
    drop     = 1'b0;
    out_lane = '0;
    if (sel_valid) begin
      if (state_q[sel_vc] == ST_HEAD) begin
        if (hd_type != HEAD_FLIT || hd_dir == IN_DIR) begin
          drop = 1'b1;
        end else begin
          present  = 1'b1;
          out_lane = hd_lane;
        end
      end else begin
        present  = 1'b1;
        out_lane = route_q[sel_vc];
      end
    end
    accept = present && fout_resp_i[out_lane].ready;
    pop    = accept || drop;

    fout_req_o = '0;
    if (present) begin
      fout_req_o[out_lane].valid = 1'b1;
      fout_req_o[out_lane].vc_id = sel_vc;
      fout_req_o[out_lane].fdata = head_data;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      state_d[v]  = state_q[v];
      route_d[v]  = route_q[v];
    end
    if (wr_en) begin
      wr_ptr_d[fin_req_i.vc_id] = wr_ptr_q[fin_req_i.vc_id] + PW'(1);
    end
    if (pop) begin
      rd_ptr_d[sel_vc] = rd_ptr_q[sel_vc] + PW'(1);
    end
    if (accept) begin
      if (state_q[sel_vc] == ST_HEAD) begin
        if (head_data[SZ_LSB +: SZW] != MIN_SIZE_FLIT) begin
          state_d[sel_vc] = ST_BODY;
          route_d[sel_vc] = out_lane;
        end
      end else if (hd_type == TAIL_FLIT) begin
        state_d[sel_vc] = ST_HEAD;
      end
    end
    err_d = drop;
  end

  // Storage carries no reset; pointer reset alone empties every FIFO.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[fin_req_i.vc_id][wr_ptr_q[fin_req_i.vc_id][AW-1:0]] <= fin_req_i.fdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        state_q[v]  <= ST_HEAD;
        route_q[v]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        state_q[v]  <= state_d[v];
        route_q[v]  <= route_d[v];
      end
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef RAVENOC_IN_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/noc_input_stage.md
Name: noc_input_stage

Overview:
- Router input stage that sits directly upstream of the per-direction output arbitration/mux stage.
- Accepts flits from one router input link and buffers them in one FIFO per virtual channel.
- Computes XY routes from head flits and holds a per-VC wormhole route lock until the packet ends.
- Presents one flit per cycle on exactly one of its 4 output-side request lanes.

Parameters:
- ROUTER_X_ID, 0, X coordinate of this router.
- ROUTER_Y_ID, 0, Y coordinate of this router.
- IN_PORT, 0, direction of this input: 0=NORTH, 1=SOUTH, 2=WEST, 3=EAST, 4=LOCAL.
- FIFO_DEPTH, 4, flits per VC FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- fin_req_i  in  s_flit_req_t  flit from link (valid, vc_id, fdata).
- fin_resp_o  out  s_flit_resp_t  ready back to link.
- fout_req_o  out  s_flit_req_t[3:0]  flit to the 4 output stages (own direction excluded).
- fout_resp_i  in  s_flit_resp_t[3:0]  ready from output stages; asserted only to the granted input.
- err_o  out  1  one-cycle pulse on a dropped flit.

Behaviour:
- Reset and interface: one clock; reset is asynchronous and active-high.
  - Reset empties all FIFOs and puts every VC FSM in ST_HEAD.
  - Reset values: fout_req_o='0, err_o=0, fin_resp_o.ready=0 during reset.
  - Reset mid-packet discards all buffered flits; there is no partial recovery.
- Write side:
  - fin_resp_o.ready = !full[fin_req_i.vc_id], combinational.
  - A write occurs when valid && ready.
  - A simultaneous read and write on a full FIFO is still refused (ready depends on full only).
- FIFO:
  - Registered storage with no bypass; a flit written in cycle N is visible at the output no earlier than N+1.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full: MSBs differ and low bits are equal. empty: pointers are equal.
- Direction to lane index: lane = dir<IN_PORT ? dir : dir-1.
- XY route, computed from the head flit at the FIFO head:
  - x_dest>X gives EAST; x_dest<X gives WEST.
  - Otherwise y_dest>Y gives SOUTH; y_dest<Y gives NORTH.
  - Otherwise LOCAL.
- Per-VC FSM:
  - ST_HEAD: the FIFO-head flit must be HEAD_FLIT.
    - A non-head flit, or a head whose route equals IN_PORT, is dropped: popped without being presented, err_o pulses for 1 cycle.
    - When a head flit is accepted downstream: if pkt_size==MIN_SIZE_FLIT stay in ST_HEAD; otherwise latch the lane into route_q[vc] and go to ST_BODY.
  - ST_BODY: flits use route_q[vc]. When a TAIL_FLIT is accepted, go to ST_HEAD. A HEAD_FLIT seen in ST_BODY is forwarded unchanged.
- VC select:
  - Choose among VCs with a non-empty FIFO.
  - If H_PRIORITY, the highest index wins; otherwise the lowest index wins.
  - Selection is re-evaluated every cycle.
- Output side:
  - Only the selected lane gets valid=1, vc_id=selected VC, and the FIFO-head fdata. All other lanes are '0.
  - Pop when fout_resp_i[lane].ready && presented valid, giving 1 flit/cycle maximum.
  - A drop pop (error case) consumes the cycle; nothing is presented that cycle.

Optional Feature:
- Macro RAVENOC_IN_ERR_CNT_EN.
- When defined: adds output err_cnt_o[15:0], a saturating count of err_o pulses, reset to 0, holding at 16'hFFFF.
- When undefined: the port is absent and no counter logic exists.

Test Plan:
- Router (1,1), IN_PORT=WEST, VC0 head with x_dest=2, y_dest=1, pkt_size=MIN_SIZE_FLIT, all readies high:
  - fout_req_o[2] (EAST) shows valid in the cycle after the write.
  - The flit pops and the FSM stays in ST_HEAD.
- Same router, 3-flit packet to (1,0) on VC1:
  - HEAD, BODY and TAIL all appear on lane 0 (NORTH) in order, 1 per cycle.
  - The FSM returns to ST_HEAD after TAIL.
- FIFO_DEPTH=4, downstream ready held low, 5 writes to VC0:
  - ready drops after the 4th write and the 5th write stalls.
  - Raising ready drains all 4 flits in order.
- VC0 and VC1 both non-empty with H_PRIORITY=1:
  - VC1 flits are presented first.
  - VC0 is presented only after VC1 empties.
- BODY flit arrives on an idle VC:
  - err_o pulses once and nothing appears on fout_req_o.
  - With RAVENOC_IN_ERR_CNT_EN defined, err_cnt_o goes to 1.
- arst asserted mid-packet with 2 flits buffered:
  - Outputs are immediately '0 and FIFOs are empty.
  - After release, a new head routes correctly.
